rr_stream_arbiter: RTL and testbench

- N-to-1 round-robin arbiter that shares one downstream valid/ready channel between N upstream requesters.
- Arbitrates at packet granularity. The grant is locked to one requester from its first beat until its beat with m_last set.
- The output stage is registered: one-deep forward register with full throughput.
- Sits in front of a shared consumer, typically a Backward_Registered slice or the sink that follows one.

---
 rtl/rr_stream_arbiter_select.sv | 29 ++
 rtl/rr_stream_arbiter.sv | 118 +++++++++++
 tb/tb_rr_stream_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_stream_arbiter_select.sv
// Rotate-priority encoder: returns the first asserted request found when
// searching from ptr upward, wrapping modulo N.
module rr_select #(
   parameter int N    = 4,
   parameter int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [ID_W-1:0] gnt_idx,
   output logic            any
);

   int idx;

   // Scan from the farthest candidate back to ptr so the nearest hit wins.
   always_comb begin
      gnt_idx = '0;
      any     = 1'b0;
      idx     = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N;
         if (req[idx]) begin
            gnt_idx = ID_W'(idx);
            any     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_stream_arbiter.sv
// N-to-1 packet-granular round-robin arbiter with a registered one-deep
// output stage; the grant stays with one requester until its last beat.
module rr_stream_arbiter #(
   parameter  int N     = 4,
   parameter  int WIDTH = 8,
   localparam int ID_W  = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         m_valid,
   input  logic [N*WIDTH-1:0]   m_data,
   input  logic [N-1:0]         m_last,
   output logic [N-1:0]         m_ready,
   output logic                 s_valid,
   output logic [WIDTH-1:0]     s_data,
   output logic                 s_last,
   output logic [ID_W-1:0]      s_id,
   input  logic                 s_ready
);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   owner_q, owner_d;
   logic              s_valid_q, s_valid_d;
   logic [WIDTH-1:0]  s_data_q, s_data_d;
   logic              s_last_q, s_last_d;
   logic [ID_W-1:0]   s_id_q, s_id_d;

   logic [ID_W-1:0]   rr_gnt;
   logic              rr_any;
   logic [ID_W-1:0]   sel;
   logic [ID_W-1:0]   sel_inc;
   logic              sel_valid;
   logic              sel_last;
   logic [WIDTH-1:0]  sel_data;
   logic              stage_free;
   logic              accept;

   rr_select #(
      .N    (N),
      .ID_W (ID_W)
   ) u_rr_select (
      .req     (m_valid),
      .ptr     (rr_ptr_q),
      .gnt_idx (rr_gnt),
      .any     (rr_any)
   );

   assign sel        = (state_q == LOCKED) ? owner_q : rr_gnt;
   assign sel_valid  = (state_q == LOCKED) ? m_valid[owner_q] : rr_any;
   assign sel_last   = m_last[sel];
   assign sel_data   = m_data[int'(sel)*WIDTH +: WIDTH];
   assign sel_inc    = (sel == ID_W'(N - 1)) ? '0 : sel + ID_W'(1);
   assign stage_free = !s_valid_q || s_ready;
   assign accept     = sel_valid && m_ready[sel];

   // While locked the owner sees ready even when idle, so it can resume at once.
   always_comb begin
      m_ready = '0;
      if (rst_n && stage_free && (state_q == LOCKED || sel_valid)) begin
         m_ready[sel] = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      owner_d   = owner_q;
      s_valid_d = s_valid_q && !s_ready;
      s_data_d  = s_data_q;
      s_last_d  = s_last_q;
      s_id_d    = s_id_q;
      if (accept) begin
         s_valid_d = 1'b1;
         s_data_d  = sel_data;
         s_last_d  = sel_last;
         s_id_d    = sel;
         if (sel_last) begin
            state_d  = IDLE;
            rr_ptr_d = sel_inc;
         end else begin
            state_d = LOCKED;
            owner_d = sel;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         owner_q   <= '0;
         s_valid_q <= 1'b0;
         s_data_q  <= '0;
         s_last_q  <= 1'b0;
         s_id_q    <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         owner_q   <= owner_d;
         s_valid_q <= s_valid_d;
         s_data_q  <= s_data_d;
         s_last_q  <= s_last_d;
         s_id_q    <= s_id_d;
      end
   end

   assign s_valid = s_valid_q;
   assign s_data  = s_data_q;
   assign s_last  = s_last_q;
   assign s_id    = s_id_q;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Bench for rr_stream_arbiter: cycle table plus scoreboard on the N=4 instance,
// hand sequences for async reset and an N=3, WIDTH=16 instance.
module tb_rr_stream_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;

   logic [3:0]  mv, ml, mr;
   logic [31:0] md;
   logic        sv, sl, sr;
   logic [7:0]  sd;
   logic [1:0]  sid;

   logic [2:0]  mv3, ml3, mr3;
   logic [47:0] md3;
   logic        sv3, sl3, sr3;
   logic [15:0] sd3;
   logic [1:0]  sid3;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rr_stream_arbiter #(.N(4), .WIDTH(8)) dut4 (
      .clk     (clk),
      .rst_n   (rst_n),
      .m_valid (mv),
      .m_data  (md),
      .m_last  (ml),
      .m_ready (mr),
      .s_valid (sv),
      .s_data  (sd),
      .s_last  (sl),
      .s_id    (sid),
      .s_ready (sr)
   );

   rr_stream_arbiter #(.N(3), .WIDTH(16)) dut3 (
      .clk     (clk),
      .rst_n   (rst_n),
      .m_valid (mv3),
      .m_data  (md3),
      .m_last  (ml3),
      .m_ready (mr3),
      .s_valid (sv3),
      .s_data  (sd3),
      .s_last  (sl3),
      .s_id    (sid3),
      .s_ready (sr3)
   );

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] data;
      logic       last;
   } beat_t;

   typedef struct {
      logic [3:0]  mv;
      logic [3:0]  ml;
      logic [31:0] md;
      logic        sr;
      logic [3:0]  rdy;
      logic        sv;
      logic [1:0]  id;
      logic        last;
      logic [7:0]  data;
   } vec_t;

   beat_t sb[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Every beat leaving dut4 must match the oldest predicted beat.
   always @(negedge clk) begin
      if (rst_n && sv && sr) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_beat", {sid, sd, sl}, 64'hFFFF);
         end else begin
            beat_t e;
            e = sb.pop_front();
            chk("sb_id", 64'(sid), 64'(e.id));
            chk("sb_data", 64'(sd), 64'(e.data));
            chk("sb_last", 64'(sl), 64'(e.last));
         end
      end
   end

   function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                               input logic r, input logic [3:0] rdy, input logic esv,
                               input logic [1:0] eid, input logic elast, input logic [7:0] edata);
      vec_t t;
      t.mv = v; t.ml = l; t.md = d; t.sr = r; t.rdy = rdy;
      t.sv = esv; t.id = eid; t.last = elast; t.data = edata;
      return t;
   endfunction

   localparam int NV = 31;
   vec_t tbl[NV];

   initial begin
      // single beats in round-robin order
      tbl[0]  = mk(4'hF, 4'hF, 32'h44332211, 1, 4'b0001, 0, 0, 0, 8'h00);
      tbl[1]  = mk(4'hF, 4'hF, 32'h44332211, 1, 4'b0010, 1, 0, 1, 8'h11);
      tbl[2]  = mk(4'hF, 4'hF, 32'h44332211, 1, 4'b0100, 1, 1, 1, 8'h22);
      tbl[3]  = mk(4'hF, 4'hF, 32'h44332211, 1, 4'b1000, 1, 2, 1, 8'h33);
      tbl[4]  = mk(4'hF, 4'hF, 32'h44332211, 1, 4'b0001, 1, 3, 1, 8'h44);
      tbl[5]  = mk(4'hF, 4'hF, 32'h44332211, 1, 4'b0010, 1, 0, 1, 8'h11);
      tbl[6]  = mk(4'h0, 4'h0, 32'h0, 1, 4'b0000, 1, 1, 1, 8'h22);
      tbl[7]  = mk(4'h0, 4'h0, 32'h0, 1, 4'b0000, 0, 0, 0, 8'h00);
      // packet lock: requester 2 three beats, requester 0 waiting
      tbl[8]  = mk(4'b0101, 4'b0001, 32'h00A00050, 1, 4'b0100, 0, 0, 0, 8'h00);
      tbl[9]  = mk(4'b0101, 4'b0001, 32'h00A10050, 1, 4'b0100, 1, 2, 0, 8'hA0);
      tbl[10] = mk(4'b0101, 4'b0101, 32'h00A20050, 1, 4'b0100, 1, 2, 0, 8'hA1);
      tbl[11] = mk(4'b0001, 4'b0001, 32'h00000050, 1, 4'b0001, 1, 2, 1, 8'hA2);
      tbl[12] = mk(4'h0, 4'h0, 32'h0, 1, 4'b0000, 1, 0, 1, 8'h50);
      tbl[13] = mk(4'h0, 4'h0, 32'h0, 1, 4'b0000, 0, 0, 0, 8'h00);
      // backpressure for five cycles on an A5 beat
      tbl[14] = mk(4'b0010, 4'b0010, 32'h0000A500, 1, 4'b0010, 0, 0, 0, 8'h00);
      for (int r = 15; r < 20; r++)
         tbl[r] = mk(4'b0100, 4'b0100, 32'h00770000, 0, 4'b0000, 1, 1, 1, 8'hA5);
      tbl[20] = mk(4'b0100, 4'b0100, 32'h00770000, 1, 4'b0100, 1, 1, 1, 8'hA5);
      tbl[21] = mk(4'h0, 4'h0, 32'h0, 1, 4'b0000, 1, 2, 1, 8'h77);
      tbl[22] = mk(4'h0, 4'h0, 32'h0, 1, 4'b0000, 0, 0, 0, 8'h00);
      // owner stall: requester 1 drops valid for three cycles, 3 waits
      tbl[23] = mk(4'b0010, 4'b0000, 32'h0000B000, 1, 4'b0010, 0, 0, 0, 8'h00);
      tbl[24] = mk(4'b1000, 4'b1000, 32'hC3000000, 1, 4'b0010, 1, 1, 0, 8'hB0);
      tbl[25] = mk(4'b1000, 4'b1000, 32'hC3000000, 1, 4'b0010, 0, 0, 0, 8'h00);
      tbl[26] = mk(4'b1000, 4'b1000, 32'hC3000000, 1, 4'b0010, 0, 0, 0, 8'h00);
      tbl[27] = mk(4'b1010, 4'b1010, 32'hC300B100, 1, 4'b0010, 0, 0, 0, 8'h00);
      tbl[28] = mk(4'b1000, 4'b1000, 32'hC3000000, 1, 4'b1000, 1, 1, 1, 8'hB1);
      tbl[29] = mk(4'h0, 4'h0, 32'h0, 1, 4'b0000, 1, 3, 1, 8'hC3);
      tbl[30] = mk(4'h0, 4'h0, 32'h0, 1, 4'b0000, 0, 0, 0, 8'h00);

      rst_n = 1'b0;
      mv = 4'hF; ml = 4'hF; md = 32'h44332211; sr = 1'b1;
      mv3 = '0; ml3 = '0; md3 = '0; sr3 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_valid", 64'(sv), 64'd0);
      chk("rst_s_data", 64'(sd), 64'd0);
      chk("rst_s_last", 64'(sl), 64'd0);
      chk("rst_s_id", 64'(sid), 64'd0);
      chk("rst_m_ready", 64'(mr), 64'd0);
      rst_n = 1'b1;

      for (int r = 0; r < NV; r++) begin
         mv = tbl[r].mv; ml = tbl[r].ml; md = tbl[r].md; sr = tbl[r].sr;
         for (int i = 0; i < 4; i++) begin
            if (tbl[r].rdy[i] && tbl[r].mv[i]) begin
               beat_t b;
               b.id = 2'(i);
               b.data = tbl[r].md[i*8 +: 8];
               b.last = tbl[r].ml[i];
               sb.push_back(b);
            end
         end
         @(negedge clk);
         chk($sformatf("row%0d_m_ready", r), 64'(mr), 64'(tbl[r].rdy));
         chk($sformatf("row%0d_s_valid", r), 64'(sv), 64'(tbl[r].sv));
         if (tbl[r].sv) begin
            chk($sformatf("row%0d_s_id", r), 64'(sid), 64'(tbl[r].id));
            chk($sformatf("row%0d_s_last", r), 64'(sl), 64'(tbl[r].last));
            chk($sformatf("row%0d_s_data", r), 64'(sd), 64'(tbl[r].data));
         end
         @(posedge clk);
         #1;
      end

      // reset asserted mid-packet with a beat held in the output stage
      mv = 4'b0001; ml = 4'b0000; md = 32'h0000005A; sr = 1'b0;
      @(posedge clk);
      #1;
      chk("lock_s_valid", 64'(sv), 64'd1);
      chk("lock_s_data", 64'(sd), 64'h5A);
      chk("lock_m_ready", 64'(mr), 64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_s_valid", 64'(sv), 64'd0);
      chk("midrst_s_data", 64'(sd), 64'd0);
      chk("midrst_m_ready", 64'(mr), 64'd0);
      mv = 4'b1000; ml = 4'b1000; md = 32'hD3000000; sr = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("postrst_m_ready", 64'(mr), 64'b1000);
      begin
         beat_t b;
         b.id = 2'd3; b.data = 8'hD3; b.last = 1'b1;
         sb.push_back(b);
      end
      @(posedge clk);
      #1;
      mv = 4'b0000;
      chk("postrst_s_valid", 64'(sv), 64'd1);
      chk("postrst_s_id", 64'(sid), 64'd3);
      @(posedge clk);
      #1;
      chk("postrst_drain", 64'(sv), 64'd0);

      // N=3: requester 2 ends a packet with everyone valid, grant wraps to 0
      mv3 = 3'b100; ml3 = 3'b000; md3 = {16'hBEEF, 16'h2222, 16'h1111};
      #1;
      chk("n3_first_ready", 64'(mr3), 64'b100);
      @(posedge clk);
      #1;
      mv3 = 3'b111; ml3 = 3'b111; md3 = {16'hBEE2, 16'h2222, 16'h1111};
      #1;
      chk("n3_locked_ready", 64'(mr3), 64'b100);
      chk("n3_beat1_id", 64'(sid3), 64'd2);
      chk("n3_beat1_data", 64'(sd3), 64'hBEEF);
      @(posedge clk);
      #1;
      chk("n3_wrap_ready", 64'(mr3), 64'b001);
      chk("n3_beat2_id", 64'(sid3), 64'd2);
      chk("n3_beat2_data", 64'(sd3), 64'hBEE2);
      chk("n3_beat2_last", 64'(sl3), 64'd1);
      @(posedge clk);
      #1;
      mv3 = 3'b000;
      chk("n3_next_id", 64'(sid3), 64'd0);
      chk("n3_next_data", 64'(sd3), 64'h1111);
      chk("n3_next_valid", 64'(sv3), 64'd1);

      repeat (2) @(posedge clk);
      #1;
      chk("sb_leftover", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
